// File: rtl/signed_digit_recombine_pkg.sv
// Shared constants and types for the signed radix-16 scalar digit path.
package ed25519_pkg;
  localparam int NDIGITS  = 64;
  localparam int DIGIT_W  = 8;
  localparam int NIB_W    = 4;
  localparam int SCALAR_W = 256;
  localparam int CARRY_W  = 6;
  localparam int ACC_W    = 10;

  typedef logic signed [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sdr_state_t;
endpackage

// File: rtl/signed_digit_recombine_if.sv
// Digit-vector in / scalar out handshake bundle for signed_digit_recombine.
interface signed_digit_recombine_if;
  import ed25519_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [NDIGITS*DIGIT_W-1:0]  e_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [SCALAR_W-1:0]         scalar_out;
  logic                        err;

  modport master (
    output in_valid, e_in, out_ready,
    input  in_ready, out_valid, scalar_out, err
  );

  modport slave (
    input  in_valid, e_in, out_ready,
    output in_ready, out_valid, scalar_out, err
  );
endinterface

// File: rtl/signed_digit_recombine_step.sv
// One digit of the carry ripple: acc = e + carry, nibble = acc mod 16, carry = floor(acc/16).
module digit_carry_step
  import ed25519_pkg::*;
(
  input  digit_t                    i_e,
  input  logic signed [CARRY_W-1:0] i_carry,
  output logic [NIB_W-1:0]          o_nibble,
  output logic signed [CARRY_W-1:0] o_carry
);
  logic signed [ACC_W-1:0] w_acc;

  always_comb begin
    w_acc    = $signed({{(ACC_W-DIGIT_W){i_e[DIGIT_W-1]}}, i_e})
             + $signed({{(ACC_W-CARRY_W){i_carry[CARRY_W-1]}}, i_carry});
    o_nibble = w_acc[NIB_W-1:0];
    o_carry  = CARRY_W'(w_acc >>> NIB_W);
  end
endmodule

// File: rtl/signed_digit_recombine.sv
// Rebuilds the unsigned 256-bit scalar from 64 signed radix-16 digits,
// rippling the carry DPC digits per clock; err flags a nonzero final carry.
module signed_digit_recombine
  import ed25519_pkg::*;
#(
  parameter int unsigned DPC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  signed_digit_recombine_if.slave bus
);
  localparam int unsigned BUF_W = NDIGITS * DIGIT_W;
  localparam int unsigned IDX_W = 7;

  sdr_state_t                r_state;
  sdr_state_t                w_state_next;
  logic [BUF_W-1:0]          r_buf;
  logic [IDX_W-1:0]          r_idx;
  logic signed [CARRY_W-1:0] r_carry;
  logic [SCALAR_W-1:0]       r_scalar;
  logic                      r_err;
  logic                      w_accept;
  logic                      w_last;
  logic signed [CARRY_W-1:0] w_carry [DPC+1];
  logic [NIB_W*DPC-1:0]      w_nibs;

  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_last     = (r_state == RUN) && (r_idx == IDX_W'(NDIGITS - DPC));
  assign w_carry[0] = r_carry;

  // Digit idx+k sits k bytes below the top of r_buf, which shifts up every RUN cycle.
  for (genvar k = 0; k < DPC; k++) begin : g_step
    digit_carry_step u_step (
      .i_e      (r_buf[BUF_W-1-DIGIT_W*k -: DIGIT_W]),
      .i_carry  (w_carry[k]),
      .o_nibble (w_nibs[NIB_W*k +: NIB_W]),
      .o_carry  (w_carry[k+1])
    );
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_carry  <= '0;
      r_scalar <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_idx    <= '0;
        r_carry  <= '0;
        r_scalar <= '0;
        r_err    <= 1'b0;
      end else if (r_state == RUN) begin
        r_idx    <= r_idx + IDX_W'(DPC);
        r_carry  <= w_carry[DPC];
        // New nibbles enter at the top; after 64/DPC shifts nibble 0 lands at bit 0.
        r_scalar <= {w_nibs, r_scalar[SCALAR_W-1:NIB_W*DPC]};
        if (w_last) r_err <= (w_carry[DPC] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf <= bus.e_in;
    else if (r_state == RUN)
      r_buf <= r_buf << (DIGIT_W * DPC);
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.scalar_out = r_scalar;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_signed_digit_recombine.sv
// Scoreboard bench for signed_digit_recombine at DPC=1 and DPC=4.
module tb_signed_digit_recombine;
  import ed25519_pkg::*;

  typedef struct {
    logic [255:0] s;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  signed_digit_recombine_if b1();
  signed_digit_recombine_if b4();

  signed_digit_recombine #(.DPC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  signed_digit_recombine #(.DPC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] pack(input int d[64]);
    logic [511:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      b = 8'(d[i]);
      r[511-8*i -: 8] = b;
    end
    return r;
  endfunction

  // Forward recoder: nibbles shifted into [-8,7], top digit absorbs the last carry.
  function automatic logic [511:0] recode(input logic [255:0] s);
    int d[64];
    int c;
    for (int i = 0; i < 64; i++) d[i] = int'(s[4*i +: 4]);
    for (int i = 0; i < 63; i++) begin
      c = (d[i] + 8) / 16;
      d[i] = d[i] - 16 * c;
      d[i+1] = d[i+1] + c;
    end
    return pack(d);
  endfunction

  // Exact signed sum of e[i]*16^i in a wide accumulator.
  function automatic exp_t model(input logic [511:0] e);
    logic signed [263:0] acc;
    logic signed [263:0] t;
    logic signed [7:0]   dg;
    exp_t r;
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      dg  = e[511-8*i -: 8];
      t   = 264'(dg);
      t   = t <<< (4 * i);
      acc = acc + t;
    end
    r.s   = acc[255:0];
    r.err = (acc[263:256] != '0);
    return r;
  endfunction

  function automatic logic [255:0] rand_scalar();
    logic [255:0] s;
    for (int k = 0; k < 8; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic v, input logic [511:0] e);
    if (w == 1) begin b1.in_valid = v; b1.e_in = e; end
    else begin b4.in_valid = v; b4.e_in = e; end
  endtask

  function automatic logic rdy(input int w);
    return (w == 1) ? b1.in_ready : b4.in_ready;
  endfunction

  function automatic logic ov(input int w);
    return (w == 1) ? b1.out_valid : b4.out_valid;
  endfunction

  task automatic run_job(input int w, input logic [511:0] e, output logic [255:0] s,
                         output logic er, output int lat, output logic tmo);
    int n;
    tmo = 1'b0;
    set_in(w, 1'b1, e);
    n = 0;
    while (!rdy(w) && n < 200) begin step(); n++; end
    if (!rdy(w)) tmo = 1'b1;
    step();
    set_in(w, 1'b0, '0);
    lat = 1;
    while (!ov(w) && lat < 200) begin step(); lat++; end
    if (!ov(w)) tmo = 1'b1;
    s  = (w == 1) ? b1.scalar_out : b4.scalar_out;
    er = (w == 1) ? b1.err : b4.err;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready1 got %b exp 1", b1.in_ready); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %b exp 0", b1.out_valid); end
    checks++; if (b1.scalar_out !== '0) begin errors++; $display("FAIL reset_scalar1 got %h exp 0", b1.scalar_out); end
    checks++; if (b1.err !== 1'b0) begin errors++; $display("FAIL reset_err1 got %b exp 0", b1.err); end
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready4 got %b exp 1", b4.in_ready); end
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid4 got %b exp 0", b4.out_valid); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero();
    logic [255:0] s; logic er; int lat; logic tmo; exp_t ex;
    q1.push_back('{s: 256'h0, err: 1'b0});
    run_job(1, '0, s, er, lat, tmo);
    ex = q1.pop_front();
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL zero_timeout got %b exp 0", tmo); end
    checks++; if (s !== ex.s) begin errors++; $display("FAIL zero_scalar got %h exp %h", s, ex.s); end
    checks++; if (er !== ex.err) begin errors++; $display("FAIL zero_err got %b exp %b", er, ex.err); end
    checks++; if (lat !== 65) begin errors++; $display("FAIL zero_latency got %0d exp 65", lat); end
  endtask

  task automatic test_patterns();
    int d[64];
    logic [511:0] pe[5];
    exp_t px[5];
    logic [255:0] s; logic er; int lat; logic tmo; exp_t ex;
    d = '{default: 0}; d[0] = 7; d[1] = -8; d[2] = 1;
    pe[0] = pack(d); px[0] = '{s: 256'h87, err: 1'b0};
    d = '{default: 0}; d[0] = -1;
    pe[1] = pack(d); px[1] = '{s: {256{1'b1}}, err: 1'b1};
    d = '{default: 0}; d[63] = 16;
    pe[2] = pack(d); px[2] = '{s: 256'h0, err: 1'b1};
    d = '{default: 0}; d[63] = -8;
    pe[3] = pack(d); px[3] = '{s: {4'h8, 252'h0}, err: 1'b1};
    d = '{default: -128};
    pe[4] = pack(d); px[4] = model(pe[4]);
    for (int i = 0; i < 5; i++) begin
      q1.push_back(px[i]);
      run_job(1, pe[i], s, er, lat, tmo);
      ex = q1.pop_front();
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL pat%0d_timeout got %b exp 0", i, tmo); end
      checks++; if (s !== ex.s) begin errors++; $display("FAIL pat%0d_scalar got %h exp %h", i, s, ex.s); end
      checks++; if (er !== ex.err) begin errors++; $display("FAIL pat%0d_err got %b exp %b", i, er, ex.err); end
    end
  endtask

  task automatic test_recode_p();
    logic [255:0] p; logic [255:0] s; logic er; int lat; logic tmo; exp_t ex;
    p = {1'b0, {255{1'b1}}} - 256'd18;
    q1.push_back('{s: p, err: 1'b0});
    run_job(1, recode(p), s, er, lat, tmo);
    ex = q1.pop_front();
    checks++; if (s !== ex.s || tmo) begin errors++; $display("FAIL p_scalar got %h exp %h", s, ex.s); end
    checks++; if (er !== ex.err) begin errors++; $display("FAIL p_err got %b exp %b", er, ex.err); end
  endtask

  task automatic test_random(input int w, input int n);
    logic [255:0] sc; logic [255:0] s; logic er; int lat; logic tmo; exp_t ex;
    int exp_lat;
    exp_lat = (w == 1) ? 65 : 17;
    for (int j = 0; j < n; j++) begin
      sc = rand_scalar();
      if (w == 1) q1.push_back('{s: sc, err: 1'b0}); else q4.push_back('{s: sc, err: 1'b0});
      run_job(w, recode(sc), s, er, lat, tmo);
      if (w == 1) ex = q1.pop_front(); else ex = q4.pop_front();
      checks++; if (s !== ex.s) begin errors++; $display("FAIL rand_dpc%0d_scalar job %0d got %h exp %h", w, j, s, ex.s); end
      checks++; if (er !== ex.err) begin errors++; $display("FAIL rand_dpc%0d_err job %0d got %b exp %b", w, j, er, ex.err); end
      checks++; if (lat !== exp_lat || tmo) begin errors++; $display("FAIL rand_dpc%0d_latency job %0d got %0d exp %0d", w, j, lat, exp_lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] sa; logic [255:0] sb; logic [255:0] s0; logic er0;
    logic [511:0] ea; logic [511:0] eb; logic stable; int n; exp_t ex;
    sa = rand_scalar(); sb = rand_scalar();
    ea = recode(sa); eb = recode(sb);
    q1.push_back('{s: sa, err: 1'b0});
    b1.out_ready = 1'b0;
    set_in(1, 1'b1, ea);
    n = 0;
    while (!rdy(1) && n < 200) begin step(); n++; end
    step();
    set_in(1, 1'b1, eb);
    n = 0;
    while (!ov(1) && n < 200) begin step(); n++; end
    s0 = b1.scalar_out; er0 = b1.err;
    ex = q1.pop_front();
    checks++; if (s0 !== ex.s || !ov(1)) begin errors++; $display("FAIL bp_scalar got %h exp %h", s0, ex.s); end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (b1.out_valid !== 1'b1 || b1.in_ready !== 1'b0 || b1.scalar_out !== s0 || b1.err !== er0)
        stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", stable); end
    q1.push_back('{s: sb, err: 1'b0});
    b1.out_ready = 1'b1;
    step();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_fall got %b exp 0", b1.out_valid); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b exp 1", b1.in_ready); end
    step();
    set_in(1, 1'b0, '0);
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got %b exp 0", b1.in_ready); end
    n = 0;
    while (!ov(1) && n < 200) begin step(); n++; end
    ex = q1.pop_front();
    checks++; if (b1.scalar_out !== ex.s || !ov(1)) begin errors++; $display("FAIL bp_next_scalar got %h exp %h", b1.scalar_out, ex.s); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [255:0] sa; logic [255:0] sb; logic [255:0] cap; int n; int nv; exp_t ex;
    sa = rand_scalar(); sb = rand_scalar();
    q1.push_back('{s: sa, err: 1'b0});
    set_in(1, 1'b1, recode(sa));
    n = 0;
    while (!rdy(1) && n < 200) begin step(); n++; end
    step();
    set_in(1, 1'b1, recode(sb));
    n = 0; nv = 0; cap = '0;
    while (!rdy(1) && n < 200) begin
      step(); n++;
      if (ov(1)) begin nv++; cap = b1.scalar_out; end
    end
    ex = q1.pop_front();
    checks++; if (nv !== 1) begin errors++; $display("FAIL b2b_single_valid got %0d exp 1", nv); end
    checks++; if (n + 1 !== 66) begin errors++; $display("FAIL b2b_period got %0d exp 66", n + 1); end
    checks++; if (cap !== ex.s) begin errors++; $display("FAIL b2b_first_scalar got %h exp %h", cap, ex.s); end
    q1.push_back('{s: sb, err: 1'b0});
    step();
    set_in(1, 1'b0, '0);
    n = 0;
    while (!ov(1) && n < 200) begin step(); n++; end
    ex = q1.pop_front();
    checks++; if (b1.scalar_out !== ex.s || !ov(1)) begin errors++; $display("FAIL b2b_second_scalar got %h exp %h", b1.scalar_out, ex.s); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int d[64]; int n; logic [255:0] s; logic er; int lat; logic tmo; exp_t ex;
    d = '{default: -1};
    set_in(1, 1'b1, pack(d));
    n = 0;
    while (!rdy(1) && n < 200) begin step(); n++; end
    step();
    set_in(1, 1'b0, '0);
    repeat (30) step();
    rst = 1'b1;
    step();
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", b1.in_ready); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", b1.out_valid); end
    checks++; if (b1.scalar_out !== '0) begin errors++; $display("FAIL midrst_scalar got %h exp 0", b1.scalar_out); end
    rst = 1'b0;
    step();
    d = '{default: 0}; d[0] = 5;
    q1.push_back('{s: 256'h5, err: 1'b0});
    run_job(1, pack(d), s, er, lat, tmo);
    ex = q1.pop_front();
    checks++; if (s !== ex.s || tmo) begin errors++; $display("FAIL midrst_new_scalar got %h exp %h", s, ex.s); end
    checks++; if (er !== ex.err) begin errors++; $display("FAIL midrst_new_err got %b exp %b", er, ex.err); end
  endtask

  initial begin
    b1.in_valid = 1'b0; b1.e_in = '0; b1.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.e_in = '0; b4.out_ready = 1'b1;
    test_reset();
    test_zero();
    test_patterns();
    test_recode_p();
    test_random(1, 150);
    test_random(4, 400);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
